// File: rtl/redmule_xif_issue_buffer_if.sv
// Handshake bundle between the XIF issue/result channels, the RedMulE dispatch port and the buffer.
// The buffer takes the slave side; the core and engine side together take the master side.
interface redmule_xif_issue_buffer_if #(
   parameter int unsigned ID_W   = 4,
   parameter int unsigned DATA_W = 32
);
   logic              issue_valid;
   logic              issue_ready;
   logic [31:0]       issue_instr;
   logic [ID_W-1:0]   issue_id;
   logic [DATA_W-1:0] issue_rs1;
   logic [DATA_W-1:0] issue_rs2;
   logic [1:0]        issue_rs_valid;
   logic              issue_accept;
   logic              issue_writeback;

   logic              dn_valid;
   logic              dn_ready;
   logic [31:0]       dn_instr;
   logic [ID_W-1:0]   dn_id;
   logic [DATA_W-1:0] dn_rs1;
   logic [DATA_W-1:0] dn_rs2;

   logic              done;
   logic              result_valid;
   logic              result_ready;
   logic [ID_W-1:0]   result_id;

   modport slave (
      input  issue_valid, issue_instr, issue_id, issue_rs1, issue_rs2, issue_rs_valid,
      output issue_ready, issue_accept, issue_writeback,
      output dn_valid, dn_instr, dn_id, dn_rs1, dn_rs2,
      input  dn_ready,
      input  done,
      output result_valid, result_id,
      input  result_ready
   );

   modport master (
      output issue_valid, issue_instr, issue_id, issue_rs1, issue_rs2, issue_rs_valid,
      input  issue_ready, issue_accept, issue_writeback,
      input  dn_valid, dn_instr, dn_id, dn_rs1, dn_rs2,
      output dn_ready,
      output done,
      input  result_valid, result_id,
      output result_ready
   );
endinterface

// File: rtl/redmule_xif_issue_buffer.sv
// XIF offload stage for RedMulE: decodes and buffers issued ops, dispatches them in order,
// and converts per-instruction completion pulses into in-order XIF result transactions.
module redmule_xif_issue_buffer #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ID_W   = 4,
   parameter int unsigned DATA_W = 32,
   parameter logic [6:0]  OPCODE = 7'b0001011
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      clear_i,
   redmule_xif_issue_buffer_if.slave xif,
   output logic                      busy_o,
   output logic                      err_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [31:0]       fifo_instr_q [DEPTH];
   logic [ID_W-1:0]   fifo_id_q    [DEPTH];
   logic [DATA_W-1:0] fifo_rs1_q   [DEPTH];
   logic [DATA_W-1:0] fifo_rs2_q   [DEPTH];
   logic [ID_W-1:0]   infl_id_q    [DEPTH];

   logic [PW-1:0] f_wr_q, f_rd_q;
   logic [PW-1:0] q_wr_q, q_rd_q;
   logic [PW-1:0] pend_q;
   logic          err_q;

   logic          match;
   logic          fifo_full, fifo_empty;
   logic          infl_full, infl_empty;
   logic [PW-1:0] infl_cnt;
   logic [PW-1:0] outstanding;
   logic          push, dispatch, retire;
   logic          done_ok, done_bad;

   assign fifo_full  = (f_wr_q[AW] != f_rd_q[AW]) && (f_wr_q[AW-1:0] == f_rd_q[AW-1:0]);
   assign fifo_empty = (f_wr_q == f_rd_q);
   assign infl_full  = (q_wr_q[AW] != q_rd_q[AW]) && (q_wr_q[AW-1:0] == q_rd_q[AW-1:0]);
   assign infl_empty = (q_wr_q == q_rd_q);

   // Dispatched but not yet completed by the engine; a done with none of these is spurious.
   assign infl_cnt    = q_wr_q - q_rd_q;
   assign outstanding = infl_cnt - pend_q;

   assign match                = (xif.issue_instr[6:0] == OPCODE);
   assign xif.issue_ready      = xif.issue_valid & (&xif.issue_rs_valid) & (~match | ~fifo_full);
   assign xif.issue_accept     = match;
   assign xif.issue_writeback  = 1'b0;

   assign xif.dn_valid = ~fifo_empty & ~infl_full;
   assign xif.dn_instr = fifo_instr_q[f_rd_q[AW-1:0]];
   assign xif.dn_id    = fifo_id_q[f_rd_q[AW-1:0]];
   assign xif.dn_rs1   = fifo_rs1_q[f_rd_q[AW-1:0]];
   assign xif.dn_rs2   = fifo_rs2_q[f_rd_q[AW-1:0]];

   assign xif.result_valid = (pend_q != '0);
   assign xif.result_id    = infl_id_q[q_rd_q[AW-1:0]];

   assign busy_o = ~fifo_empty | ~infl_empty;
   assign err_o  = err_q;

   // clear_i suppresses every handshake side effect in its cycle.
   assign push     = xif.issue_valid & xif.issue_ready & match & ~clear_i;
   assign dispatch = xif.dn_valid & xif.dn_ready & ~clear_i;
   assign retire   = xif.result_valid & xif.result_ready & ~clear_i;
   assign done_ok  = xif.done & ~clear_i & (outstanding != '0);
   assign done_bad = xif.done & ~clear_i & (outstanding == '0);

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_instr_q[f_wr_q[AW-1:0]] <= xif.issue_instr;
         fifo_id_q[f_wr_q[AW-1:0]]    <= xif.issue_id;
         fifo_rs1_q[f_wr_q[AW-1:0]]   <= xif.issue_rs1;
         fifo_rs2_q[f_wr_q[AW-1:0]]   <= xif.issue_rs2;
      end
      if (dispatch) begin
         infl_id_q[q_wr_q[AW-1:0]] <= xif.dn_id;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         f_wr_q <= '0;
         f_rd_q <= '0;
         q_wr_q <= '0;
         q_rd_q <= '0;
      end else if (clear_i) begin
         f_wr_q <= '0;
         f_rd_q <= '0;
         q_wr_q <= '0;
         q_rd_q <= '0;
      end else begin
         if (push)     f_wr_q <= f_wr_q + PW'(1);
         if (dispatch) f_rd_q <= f_rd_q + PW'(1);
         if (dispatch) q_wr_q <= q_wr_q + PW'(1);
         if (retire)   q_rd_q <= q_rd_q + PW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_q <= '0;
         err_q  <= 1'b0;
      end else if (clear_i) begin
         pend_q <= '0;
         err_q  <= 1'b0;
      end else begin
         case ({done_ok, retire})
            2'b10:   pend_q <= pend_q + PW'(1);
            2'b01:   pend_q <= pend_q - PW'(1);
            default: pend_q <= pend_q;
         endcase
         if (done_bad) err_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_redmule_xif_issue_buffer.sv
// Self-checking bench: directed scenarios plus random traffic, all checked every cycle
// against a queue-based reference model of the issue buffer.
module tb_redmule_xif_issue_buffer;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned ID_W   = 4;
   localparam int unsigned DATA_W = 32;
   localparam logic [6:0]  OPC    = 7'b0001011;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   logic clear_i = 1'b0;
   logic busy_o, err_o;

   redmule_xif_issue_buffer_if #(.ID_W(ID_W), .DATA_W(DATA_W)) xif ();

   redmule_xif_issue_buffer #(
      .DEPTH(DEPTH), .ID_W(ID_W), .DATA_W(DATA_W), .OPCODE(OPC)
   ) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .xif     (xif),
      .busy_o  (busy_o),
      .err_o   (err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0]       instr;
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] rs1;
      logic [DATA_W-1:0] rs2;
   } entry_t;

   entry_t          m_fifo[$];
   logic [ID_W-1:0] m_infl[$];
   int              m_pend;
   bit              m_err;

   int n_vec = 0;
   int n_err = 0;

   logic            obs_ready, obs_accept, obs_dn_valid, obs_res_valid, obs_busy, obs_err;
   logic [ID_W-1:0] obs_dn_id, obs_res_id;
   logic [DATA_W-1:0] obs_dn_rs1, obs_dn_rs2;
   logic [31:0]     obs_dn_instr;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_fifo.delete();
      m_infl.delete();
      m_pend = 0;
      m_err  = 1'b0;
   endtask

   task automatic drive_idle();
      xif.issue_valid    = 1'b0;
      xif.issue_instr    = '0;
      xif.issue_id       = '0;
      xif.issue_rs1      = '0;
      xif.issue_rs2      = '0;
      xif.issue_rs_valid = 2'b00;
      xif.dn_ready       = 1'b0;
      xif.done           = 1'b0;
      xif.result_ready   = 1'b0;
      clear_i            = 1'b0;
   endtask

   task automatic drive_issue(input logic [31:0] instr, input logic [ID_W-1:0] id,
                              input logic [DATA_W-1:0] rs1, input logic [DATA_W-1:0] rs2);
      xif.issue_valid    = 1'b1;
      xif.issue_instr    = instr;
      xif.issue_id       = id;
      xif.issue_rs1      = rs1;
      xif.issue_rs2      = rs2;
      xif.issue_rs_valid = 2'b11;
   endtask

   // One clock: compare outputs against the model, then advance the model at the edge.
   task automatic step();
      bit     m, e_ir, e_dv, e_rv;
      int     outst;
      entry_t e;
      #1;
      if (!rst_ni) model_reset();
      m    = (xif.issue_instr[6:0] == OPC);
      e_ir = xif.issue_valid && (xif.issue_rs_valid == 2'b11) && (!m || m_fifo.size() < DEPTH);
      e_dv = (m_fifo.size() > 0) && (m_infl.size() < DEPTH);
      e_rv = (m_pend > 0);
      check_val("issue_ready", xif.issue_ready, e_ir);
      if (xif.issue_valid) check_val("issue_accept", xif.issue_accept, m);
      check_val("issue_writeback", xif.issue_writeback, 0);
      check_val("dn_valid", xif.dn_valid, e_dv);
      if (e_dv) begin
         check_val("dn_instr", xif.dn_instr, m_fifo[0].instr);
         check_val("dn_id", xif.dn_id, m_fifo[0].id);
         check_val("dn_rs1", xif.dn_rs1, m_fifo[0].rs1);
         check_val("dn_rs2", xif.dn_rs2, m_fifo[0].rs2);
      end
      check_val("result_valid", xif.result_valid, e_rv);
      if (e_rv) check_val("result_id", xif.result_id, m_infl[0]);
      check_val("busy", busy_o, (m_fifo.size() > 0) || (m_infl.size() > 0));
      check_val("err", err_o, m_err);
      obs_ready     = xif.issue_ready;
      obs_accept    = xif.issue_accept;
      obs_dn_valid  = xif.dn_valid;
      obs_dn_id     = xif.dn_id;
      obs_dn_instr  = xif.dn_instr;
      obs_dn_rs1    = xif.dn_rs1;
      obs_dn_rs2    = xif.dn_rs2;
      obs_res_valid = xif.result_valid;
      obs_res_id    = xif.result_id;
      obs_busy      = busy_o;
      obs_err       = err_o;
      @(posedge clk_i);
      if (rst_ni) begin
         if (clear_i) begin
            model_reset();
         end else begin
            outst = m_infl.size() - m_pend;
            if (e_rv && xif.result_ready) begin
               void'(m_infl.pop_front());
               m_pend--;
            end
            if (e_dv && xif.dn_ready) begin
               e = m_fifo.pop_front();
               m_infl.push_back(e.id);
            end
            if (e_ir && m) begin
               e.instr = xif.issue_instr;
               e.id    = xif.issue_id;
               e.rs1   = xif.issue_rs1;
               e.rs2   = xif.issue_rs2;
               m_fifo.push_back(e);
            end
            if (xif.done) begin
               if (outst == 0) m_err = 1'b1;
               else            m_pend++;
            end
         end
      end
      @(negedge clk_i);
   endtask

   task automatic drive_random();
      logic [31:0] w;
      int outst;
      w = $urandom;
      if ($urandom_range(3, 0) != 0) begin
         w[6:0] = OPC;
      end else if (w[6:0] == OPC) begin
         w[0] = ~w[0];
      end
      xif.issue_valid    = $urandom_range(1, 0) == 1;
      xif.issue_instr    = w;
      xif.issue_id       = ID_W'($urandom);
      xif.issue_rs1      = $urandom;
      xif.issue_rs2      = $urandom;
      xif.issue_rs_valid = ($urandom_range(9, 0) != 0) ? 2'b11 : 2'($urandom);
      xif.dn_ready       = $urandom_range(2, 0) != 0;
      xif.result_ready   = $urandom_range(2, 0) != 0;
      outst = m_infl.size() - m_pend;
      xif.done = (outst > 0) ? ($urandom_range(2, 0) == 0) : ($urandom_range(49, 0) == 0);
      clear_i  = $urandom_range(149, 0) == 0;
   endtask

   initial begin
      model_reset();
      drive_idle();
      @(negedge clk_i);
      step();
      check_val("rst_issue_ready", obs_ready, 0);
      check_val("rst_dn_valid", obs_dn_valid, 0);
      check_val("rst_result_valid", obs_res_valid, 0);
      check_val("rst_busy", obs_busy, 0);
      check_val("rst_err", obs_err, 0);
      step();
      rst_ni = 1'b1;

      // single op
      drive_issue(32'h0000_000B, 4'd3, 32'h100, 32'h200);
      xif.dn_ready = 1'b1;
      xif.result_ready = 1'b1;
      step();
      check_val("single_accept", obs_accept, 1);
      check_val("single_ready", obs_ready, 1);
      check_val("single_dn_before", obs_dn_valid, 0);
      xif.issue_valid = 1'b0;
      step();
      check_val("single_dn_valid", obs_dn_valid, 1);
      check_val("single_dn_id", obs_dn_id, 3);
      check_val("single_dn_rs1", obs_dn_rs1, 32'h100);
      check_val("single_dn_rs2", obs_dn_rs2, 32'h200);
      repeat (4) step();
      xif.done = 1'b1;
      step();
      check_val("single_res_early", obs_res_valid, 0);
      xif.done = 1'b0;
      step();
      check_val("single_res_valid", obs_res_valid, 1);
      check_val("single_res_id", obs_res_id, 3);
      step();
      check_val("single_busy_after", obs_busy, 0);

      // non-matching opcode
      drive_idle();
      drive_issue(32'h0000_0033, 4'd7, 32'h1, 32'h2);
      step();
      check_val("nonmatch_ready", obs_ready, 1);
      check_val("nonmatch_accept", obs_accept, 0);
      drive_idle();
      step();
      check_val("nonmatch_dn_valid", obs_dn_valid, 0);

      // fill the issue FIFO with dispatch blocked
      for (int i = 0; i < 5; i++) begin
         drive_issue({25'(i), OPC}, ID_W'(i), 32'(i * 16), 32'(i * 32));
         step();
         check_val("fill_ready", obs_ready, (i < 4) ? 1 : 0);
      end
      xif.dn_ready = 1'b1;
      step();
      check_val("fill_pop_no_free", obs_ready, 0);
      check_val("fill_dn_id0", obs_dn_id, 0);
      step();
      check_val("fill_id4_accept", obs_ready, 1);
      check_val("fill_dn_id1", obs_dn_id, 1);
      xif.issue_valid = 1'b0;
      for (int i = 2; i < 4; i++) begin
         step();
         check_val("fill_dn_order", obs_dn_id, i);
      end
      step();
      check_val("fill_infl_full", obs_dn_valid, 0);
      drive_idle();
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;

      // result backpressure
      xif.dn_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_issue({25'h1234, OPC}, ID_W'(i), 32'(i), 32'(i + 8));
         step();
      end
      xif.issue_valid = 1'b0;
      step();
      xif.done = 1'b1;
      repeat (3) step();
      xif.done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check_val("bp_hold_valid", obs_res_valid, 1);
         check_val("bp_hold_id", obs_res_id, 0);
      end
      xif.result_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_val("bp_res_valid", obs_res_valid, 1);
         check_val("bp_res_id", obs_res_id, i);
      end
      step();
      check_val("bp_drained", obs_res_valid, 0);

      // spurious completion
      drive_idle();
      xif.done = 1'b1;
      step();
      xif.done = 1'b0;
      step();
      check_val("spur_err", obs_err, 1);
      step();
      check_val("spur_err_sticky", obs_err, 1);
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      step();
      check_val("spur_err_clear", obs_err, 0);

      // clear with two queued and one in flight
      xif.result_ready = 1'b1;
      drive_issue({25'h0, OPC}, 4'd9, 32'h9, 32'h9);
      xif.dn_ready = 1'b1;
      step();
      drive_issue({25'h1, OPC}, 4'd10, 32'hA, 32'hA);
      xif.dn_ready = 1'b0;
      step();
      drive_issue({25'h2, OPC}, 4'd11, 32'hB, 32'hB);
      step();
      check_val("clr_pre_busy", obs_busy, 1);
      drive_idle();
      xif.result_ready = 1'b1;
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      step();
      check_val("clr_dn_valid", obs_dn_valid, 0);
      check_val("clr_res_valid", obs_res_valid, 0);
      check_val("clr_busy", obs_busy, 0);
      xif.done = 1'b1;
      step();
      xif.done = 1'b0;
      repeat (3) begin
         step();
         check_val("clr_no_result", obs_res_valid, 0);
      end
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;

      // random traffic with a mid-run reset
      for (int i = 0; i < 3000; i++) begin
         drive_random();
         rst_ni = !(i == 1500 || i == 1501);
         step();
      end
      rst_ni = 1'b1;
      drive_idle();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
